// File: rtl/fp_mul_norm_pipe_pkg.sv
// Shared constants for the FP multiplier normaliser: default datapath widths,
// exponent bias and the shift-amount width helper.
package fp_mul_norm_pipe_pkg;

    localparam int PRODWIDTH    = 48;   // 2 x significand width, implied 1 included
    localparam int EXPWIDTH     = 8;    // exponent field width
    localparam int BIAS_DEFAULT = 127;  // exponent bias

    // Width needed to hold a shift amount of 0..pw inclusive.
    function automatic int fpnorm_shw(input int pw);
        return $clog2(pw) + 1;
    endfunction

    localparam int FPNORM_SHW = fpnorm_shw(PRODWIDTH);

endpackage

// File: rtl/fp_mul_norm_pipe_lzc.sv
// fpnorm_lzc: combinational PW-bit leading-zero counter (result 0..PW).
module fpnorm_lzc #(
    parameter int PW  = 48,
    parameter int SHW = 7
) (
    input  logic [PW-1:0]  value,
    output logic [SHW-1:0] count
);

    // Scan from LSB upward so the most significant set bit decides the count.
    always_comb begin
        count = SHW'(PW);
        for (int i = 0; i < PW; i++) begin
            if (value[i]) begin
                count = SHW'(PW - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mul_norm_pipe.sv
// fp_mul_norm_pipe: two-stage valid/ready normaliser between the mantissa
// multiplier and the rounder. Produces the left-aligned fraction (implied 1
// removed), biased exponent, sticky bit and tiny/overflow/zero flags.
// Build option FPNORM_LZC_EN: full leading-zero count and right shift into the
// denormal range. Without it, legacy mode looks only at the top two product
// bits and never shifts right (sticky_out is always 0).
module fp_mul_norm_pipe
    import fp_mul_norm_pipe_pkg::*;
#(
    parameter int PW   = PRODWIDTH,
    parameter int EW   = EXPWIDTH,
    parameter int BIAS = BIAS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PW-1:0]        prod,
    input  logic signed [EW+1:0] exp_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PW-1:0]        norm_out,
    output logic [EW-1:0]        exp_out,
    output logic                 sticky_out,
    output logic                 tiny_out,
    output logic                 ovf_out,
    output logic                 zero_out
);

    localparam int SHW = fpnorm_shw(PW);
    // Exponent math is one bit wider than exp_sum so exp_sum+1-lz never wraps.
    localparam int XW  = EW + 3;

    localparam logic signed [XW-1:0] ONE     = XW'(1);
    localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EW) - 1);

    // The bias is already folded into exp_sum upstream; reject a value that
    // could not describe a valid exponent range for this field width.
    if (BIAS <= 0 || BIAS >= (1 << EW) - 1) begin : g_bias_check
        $error("fp_mul_norm_pipe: BIAS out of range for EW");
    end

    // ------------------------------------------------------------------
    // Handshake: each stage advances when it is empty or its consumer moves.
    // ------------------------------------------------------------------
    logic s1_valid, s2_valid;
    logic s1_en, s2_en;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Leading-zero count of the incoming product.
    // ------------------------------------------------------------------
    logic [SHW-1:0] lz_in;

`ifdef FPNORM_LZC_EN
    fpnorm_lzc #(
        .PW  (PW),
        .SHW (SHW)
    ) u_lzc (
        .value (prod),
        .count (lz_in)
    );
`else
    // Product lies in [1,4) for normal operands, so only the top bit matters.
    assign lz_in = prod[PW-1] ? '0 : SHW'(1);
`endif

    // ------------------------------------------------------------------
    // Stage 1: register the operands and their leading-zero count.
    // ------------------------------------------------------------------
    logic [PW-1:0]        s1_prod;
    logic signed [EW+1:0] s1_exp_sum;
    logic [SHW-1:0]       s1_lz;

    // Capture an accepted beat; reset empties the stage and zeroes its data.
    // NOTE: state is written with non-blocking (<=) so every register samples
    // pre-edge values; blocking here would let stages race within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_prod    <= '0;
            s1_exp_sum <= '0;
            s1_lz      <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod    <= prod;
                s1_exp_sum <= exp_sum;
                s1_lz      <= lz_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2: exponent classification and barrel shift.
    // ------------------------------------------------------------------
    logic signed [XW-1:0] k;      // exp_sum + 1
    logic signed [XW-1:0] e_res;  // exp_sum + 1 - lz
    logic signed [XW-1:0] lz_x;

    assign lz_x  = XW'(s1_lz);
    assign k     = XW'(s1_exp_sum) + ONE;
    assign e_res = k - lz_x;

    logic [PW-1:0] n_norm;
    logic [EW-1:0] n_exp;
    logic          n_sticky, n_tiny, n_ovf, n_zero;

`ifdef FPNORM_LZC_EN
    logic [XW-1:0] rsh;
    assign rsh = XW'(-k);
`endif

    // Pick one of zero / overflow / normal / tiny and form the result.
    // NOTE: every output gets a default before the case logic so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        n_norm   = '0;
        n_exp    = '0;
        n_sticky = 1'b0;
        n_tiny   = 1'b0;
        n_ovf    = 1'b0;
        n_zero   = 1'b0;
        if (s1_prod == '0) begin
            n_zero = 1'b1;
        end else if (e_res >= EXP_OVF) begin
            n_ovf = 1'b1;
            n_exp = '1;
        end else if (e_res >= ONE) begin
            // Shifting one past the leading 1 drops the implied bit.
            n_norm = s1_prod << (s1_lz + SHW'(1));
            n_exp  = e_res[EW-1:0];
        end else begin
            n_tiny = 1'b1;
`ifdef FPNORM_LZC_EN
            if (!k[XW-1]) begin
                // k <= lz here, so the left shift never loses a set bit.
                n_norm = s1_prod << k[SHW-1:0];
            end else if (rsh >= XW'(PW)) begin
                n_sticky = |s1_prod;
            end else begin
                n_norm   = s1_prod >> rsh[SHW-1:0];
                n_sticky = |(s1_prod & ~({PW{1'b1}} << rsh[SHW-1:0]));
            end
`else
            n_norm = s1_prod[PW-1] ? s1_prod : (s1_prod << 1);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output register, held while the consumer stalls.
    // ------------------------------------------------------------------
    // Load a new result only when the output slot is free or being drained.
    // NOTE: the data registers are reset as well as the valid bit, so the
    // outputs read as zero after reset rather than stale operand values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            norm_out   <= '0;
            exp_out    <= '0;
            sticky_out <= 1'b0;
            tiny_out   <= 1'b0;
            ovf_out    <= 1'b0;
            zero_out   <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                norm_out   <= n_norm;
                exp_out    <= n_exp;
                sticky_out <= n_sticky;
                tiny_out   <= n_tiny;
                ovf_out    <= n_ovf;
                zero_out   <= n_zero;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_pipe.sv
// Scoreboard bench for fp_mul_norm_pipe (PW=48, EW=8, BIAS=127). The driver
// pushes the hand-computed result of each accepted beat; a monitor pops and
// compares whenever a beat leaves the DUT. Vectors follow FPNORM_LZC_EN.
module tb_fp_mul_norm_pipe;

    typedef struct packed {
        logic [47:0] norm;
        logic [7:0]  exp;
        logic        sticky;
        logic        tiny;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        logic [47:0]        p;
        logic signed [9:0]  e;
        res_t               r;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [47:0]        prod;
    logic signed [9:0]  exp_sum;
    logic               out_valid;
    logic               out_ready;
    logic [47:0]        norm_out;
    logic [7:0]         exp_out;
    logic               sticky_out, tiny_out, ovf_out, zero_out;

    fp_mul_norm_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prod       (prod),
        .exp_sum    (exp_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .norm_out   (norm_out),
        .exp_out    (exp_out),
        .sticky_out (sticky_out),
        .tiny_out   (tiny_out),
        .ovf_out    (ovf_out),
        .zero_out   (zero_out)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic add_vec(input logic [47:0] p, input int e, input logic [47:0] n,
                           input logic [7:0] x, input logic s, input logic t,
                           input logic o, input logic z);
        vec_t v;
        v.p        = p;
        v.e        = 10'(e);
        v.r.norm   = n;
        v.r.exp    = x;
        v.r.sticky = s;
        v.r.tiny   = t;
        v.r.ovf    = o;
        v.r.zero   = z;
        vecs.push_back(v);
    endtask

    // Present one beat (called just after a rising edge) until accepted.
    task automatic drive_beat(input vec_t v);
        bit got = 0;
        in_valid = 1'b1;
        prod     = v.p;
        exp_sum  = v.e;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v.r);
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare each departing beat and verify outputs hold while stalled.
    res_t held;
    bit   stalled = 0;
    initial begin
        res_t act, req;
        forever begin
            @(negedge clk);
            act = {norm_out, exp_out, sticky_out, tiny_out, ovf_out, zero_out};
            if (reset || !out_valid) begin
                stalled = 0;
            end else begin
                if (stalled) check("stall_hold", 64'(act), 64'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        req = exp_q.pop_front();
                        check("beat", 64'(act), 64'(req));
                    end
                    stalled = 0;
                end else begin
                    held    = act;
                    stalled = 1;
                end
            end
        end
    end

    initial begin
        int idx;
        reset     = 1'b1;
        in_valid  = 1'b0;
        prod      = '0;
        exp_sum   = '0;
        out_ready = 1'b1;

        // Vectors valid in both build modes.
        add_vec(48'h4000_0000_0000, 127, 48'h0, 8'd127, 0, 0, 0, 0);
        add_vec(48'h8000_0000_0000, 127, 48'h0, 8'd128, 0, 0, 0, 0);
        add_vec(48'h0,              127, 48'h0, 8'd0,   0, 0, 0, 1);
        add_vec(48'h8000_0000_0000, 254, 48'h0, 8'hFF,  0, 0, 1, 0);
        add_vec(48'h8000_0000_0000, 253, 48'h0, 8'hFE,  0, 0, 0, 0);
        add_vec(48'h8000_0000_0000, 0,   48'h0, 8'd1,   0, 0, 0, 0);
        add_vec(48'h4000_0000_0000, 1,   48'h0, 8'd1,   0, 0, 0, 0);
        add_vec(48'h0,              254, 48'h0, 8'd0,   0, 0, 0, 1);
        add_vec(48'h8000_0010_0001, 10,  48'h0000_0020_0002, 8'd11, 0, 0, 0, 0);
        add_vec(48'h8000_0000_0005, -1,  48'h8000_0000_0005, 8'd0,  0, 1, 0, 0);
        add_vec(48'h4000_0000_0003, 0,   48'h8000_0000_0006, 8'd0,  0, 1, 0, 0);
`ifdef FPNORM_LZC_EN
        add_vec(48'h3,              200, 48'h8000_0000_0000, 8'd155, 0, 0, 0, 0);
        add_vec(48'h4000_0000_0001, -3,  48'h1000_0000_0000, 8'd0,   1, 1, 0, 0);
        add_vec(48'h4000_0000_0001, -60, 48'h0,              8'd0,   1, 1, 0, 0);
        add_vec(48'h4000_0000_0002, -2,  48'h2000_0000_0001, 8'd0,   0, 1, 0, 0);
        add_vec(48'h8000_0000_0000, -48, 48'h1,              8'd0,   0, 1, 0, 0);
        add_vec(48'h8000_0000_0000, -49, 48'h0,              8'd0,   1, 1, 0, 0);
`else
        add_vec(48'h3,              200, 48'hC,              8'd200, 0, 0, 0, 0);
        add_vec(48'h4000_0000_0001, -3,  48'h8000_0000_0002, 8'd0,   0, 1, 0, 0);
        add_vec(48'h1,              5,   48'h4,              8'd5,   0, 0, 0, 0);
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_data", 64'({norm_out, exp_out, sticky_out, tiny_out, ovf_out, zero_out}), 64'd0);

        // Directed vectors streamed back to back at full rate.
        foreach (vecs[i]) drive_beat(vecs[i]);
        drain("drain_directed");

        // Backpressure: five beats offered with the output stalled.
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            prod    = vecs[idx].p;
            exp_sum = vecs[idx].e;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(vecs[idx].r);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        check("stall_accepted", 64'(idx), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);

        // Release with a toggling out_ready; remaining beats follow.
        for (int c = 0; c < 200 && (idx < 5 || exp_q.size() != 0); c++) begin
            out_ready = (c % 3) != 0;
            in_valid  = idx < 5;
            if (idx < 5) begin
                prod    = vecs[idx].p;
                exp_sum = vecs[idx].e;
            end
            @(negedge clk);
            if (idx < 5 && in_ready) begin
                exp_q.push_back(vecs[idx].r);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("toggle_all_sent", 64'(idx), 64'd5);
        drain("drain_toggle");

        // Reset mid-stream discards beats in flight.
        drive_beat(vecs[0]);
        drive_beat(vecs[1]);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_still_idle", 64'(out_valid), 64'd0);

        // Recovery after reset.
        drive_beat(vecs[3]);
        drain("drain_recover");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
